// File: rtl/intel_vvp_icon_frame_scheduler.sv
// intel_vvp_icon_frame_scheduler: per-frame IIP/token/EOF control-stream source; optional inter-frame gap via VVP_ICON_SCHED_FRAME_GAP_EN
module intel_vvp_icon_frame_scheduler #(
  parameter int CTRL_WIDTH = 32,
  parameter int DIM_WIDTH = 16,
  parameter int FCOUNT_WIDTH = 16,
  parameter int GAP_WIDTH = 8,
  localparam int USER_WIDTH = (CTRL_WIDTH + 7) / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    cfg_ext_mode,
  input  logic [DIM_WIDTH-1:0]    cfg_width,
  input  logic [DIM_WIDTH-1:0]    cfg_height,
  input  logic [3:0]              cfg_bps,
  input  logic [FCOUNT_WIDTH-1:0] cfg_frames,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    run_done,
  output logic [FCOUNT_WIDTH-1:0] frame_count,
  output logic                    ctrl_tvalid,
  output logic [CTRL_WIDTH-1:0]   ctrl_tdata,
  output logic                    ctrl_tlast,
  output logic [USER_WIDTH-1:0]   ctrl_tuser,
  input  logic                    ctrl_tready
);
  localparam logic [3:0] VVP_CTRL_PKT_IP = 4'd1;
  localparam logic [3:0] VVP_CTRL_PKT_EOF = 4'd2;
  localparam logic [1:0] VVP_IP_PROGRESSIVE_NATIVE_0 = 2'd0;
  localparam logic [1:0] COLSPACE_RGB = 2'd0;
  localparam logic [1:0] COSITE_TL = 2'd0;
  localparam logic [1:0] SUBSA_444 = 2'd0;
  typedef enum logic [2:0] {IDLE, LATCH, SEND_IIP, SEND_TOKENS, SEND_EOF, GAP} state_t;
  state_t state;
  logic [DIM_WIDTH-1:0] w_q, h_q, line, h_in, w_in;
  logic [3:0] bps_q, bps_in;
  logic ext_q;
  logic [FCOUNT_WIDTH-1:0] frames_q, next_count;
  logic [1:0] beat;
  logic [CTRL_WIDTH-1:0] iip_next;
  logic hs, frame_end, run_end, cont, gap_go, gap_end, load;
`ifdef VVP_ICON_SCHED_FRAME_GAP_EN
  logic [GAP_WIDTH-1:0] gap_q, gap_cnt;
`else
  logic unused_gap;
  assign unused_gap = ^cfg_gap;
`endif
  assign busy = state != IDLE;
  always_comb begin
    hs = ctrl_tvalid & ctrl_tready;
    h_in = cfg_height == '0 ? DIM_WIDTH'(1) : cfg_height;
    w_in = cfg_width == '0 ? DIM_WIDTH'(1) : cfg_width;
    bps_in = cfg_bps == 4'd0 ? 4'd0 : cfg_bps - 4'd1;
    next_count = frame_count + FCOUNT_WIDTH'(1);
    frame_end = hs & ((state == SEND_EOF & beat[0]) | (state == SEND_TOKENS & line == '0 & ext_q));
    run_end = frames_q != '0 && next_count == frames_q;
    cont = frame_end & ~run_end & enable;
`ifdef VVP_ICON_SCHED_FRAME_GAP_EN
    gap_go = cont & (gap_q != '0);
    gap_end = state == GAP && gap_cnt == GAP_WIDTH'(1);
`else
    gap_go = 1'b0;
    gap_end = 1'b0;
`endif
    // A continuing frame reloads straight from frame end so frames run without a bubble
    load = state == LATCH | (cont & ~gap_go) | (gap_end & enable);
    iip_next = beat == 2'd0 ? CTRL_WIDTH'(w_q - DIM_WIDTH'(1)) :
               beat == 2'd1 ? CTRL_WIDTH'(h_q - DIM_WIDTH'(1)) :
               CTRL_WIDTH'({COLSPACE_RGB, COSITE_TL, SUBSA_444, bps_q});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frame_done <= 1'b0;
      run_done <= 1'b0;
      frame_count <= '0;
      ctrl_tvalid <= 1'b0;
      ctrl_tdata <= '0;
      ctrl_tlast <= 1'b0;
      ctrl_tuser <= '0;
      w_q <= '0;
      h_q <= '0;
      line <= '0;
      bps_q <= '0;
      ext_q <= 1'b0;
      frames_q <= '0;
      beat <= '0;
`ifdef VVP_ICON_SCHED_FRAME_GAP_EN
      gap_q <= '0;
      gap_cnt <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (!enable) run_done <= 1'b0;
      case (state)
        IDLE: if (enable && !run_done) begin
          state <= LATCH;
          frame_count <= '0;
        end
        SEND_IIP: if (hs) begin
          if (beat == 2'd3) begin
            state <= SEND_TOKENS;
            line <= h_q - DIM_WIDTH'(1);
            ctrl_tdata <= '0;
            ctrl_tuser <= USER_WIDTH'(1);
            ctrl_tlast <= 1'b1;
          end else begin
            beat <= beat + 2'd1;
            ctrl_tdata <= iip_next;
            ctrl_tuser <= '0;
            ctrl_tlast <= beat == 2'd2;
          end
        end
        SEND_TOKENS: if (hs) begin
          if (line != '0) begin
            line <= line - DIM_WIDTH'(1);
            ctrl_tuser <= '0;
          end else if (!ext_q) begin
            state <= SEND_EOF;
            beat <= 2'd0;
            ctrl_tdata <= CTRL_WIDTH'(VVP_CTRL_PKT_EOF);
            ctrl_tuser <= USER_WIDTH'(2);
            ctrl_tlast <= 1'b0;
          end
        end
        SEND_EOF: if (hs && !beat[0]) begin
          beat <= 2'd1;
          ctrl_tdata <= '0;
          ctrl_tuser <= '0;
          ctrl_tlast <= 1'b1;
        end
`ifdef VVP_ICON_SCHED_FRAME_GAP_EN
        GAP: begin
          gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          if (gap_end && !enable) state <= IDLE;
        end
`endif
        default: ;
      endcase
      if (frame_end) begin
        ctrl_tvalid <= 1'b0;
        frame_done <= 1'b1;
        frame_count <= next_count;
        if (run_end) begin
          run_done <= 1'b1;
          state <= IDLE;
        end else if (!enable) state <= IDLE;
`ifdef VVP_ICON_SCHED_FRAME_GAP_EN
        else if (gap_go) begin
          state <= GAP;
          gap_cnt <= gap_q;
        end
`endif
      end
      if (load) begin
        w_q <= w_in;
        h_q <= h_in;
        bps_q <= bps_in;
        ext_q <= cfg_ext_mode;
        frames_q <= cfg_frames;
`ifdef VVP_ICON_SCHED_FRAME_GAP_EN
        gap_q <= cfg_gap;
`endif
        state <= cfg_ext_mode ? SEND_TOKENS : SEND_IIP;
        beat <= 2'd0;
        line <= h_in - DIM_WIDTH'(1);
        ctrl_tvalid <= 1'b1;
        ctrl_tdata <= cfg_ext_mode ? '0 : CTRL_WIDTH'({VVP_IP_PROGRESSIVE_NATIVE_0, VVP_CTRL_PKT_IP});
        ctrl_tuser <= cfg_ext_mode ? USER_WIDTH'(1) : USER_WIDTH'(2);
        ctrl_tlast <= cfg_ext_mode;
      end
    end
  end
endmodule

// File: tb/tb_intel_vvp_icon_frame_scheduler.sv
// tb_intel_vvp_icon_frame_scheduler: directed checks of the icon frame scheduler control stream
module tb_intel_vvp_icon_frame_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic cfg_ext_mode = 1'b0;
  logic [15:0] cfg_width = '0;
  logic [15:0] cfg_height = '0;
  logic [3:0] cfg_bps = '0;
  logic [15:0] cfg_frames = '0;
  logic [7:0] cfg_gap = '0;
  logic ctrl_tready = 1'b0;
  logic busy, frame_done, run_done, ctrl_tvalid, ctrl_tlast;
  logic [15:0] frame_count;
  logic [31:0] ctrl_tdata;
  logic [3:0] ctrl_tuser;
  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int ed [7] = '{1, 7, 0, 7, 0, 2, 0};
  int eu [7] = '{2, 0, 0, 0, 1, 2, 0};
  int el [7] = '{0, 0, 0, 1, 1, 0, 1};
  logic [31:0] rd [16];
  logic [3:0] ru [16];
  logic rl [16];

  intel_vvp_icon_frame_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_ext_mode(cfg_ext_mode),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_bps(cfg_bps),
    .cfg_frames(cfg_frames), .cfg_gap(cfg_gap), .busy(busy),
    .frame_done(frame_done), .run_done(run_done), .frame_count(frame_count),
    .ctrl_tvalid(ctrl_tvalid), .ctrl_tdata(ctrl_tdata), .ctrl_tlast(ctrl_tlast),
    .ctrl_tuser(ctrl_tuser), .ctrl_tready(ctrl_tready)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input int d, input int u, input int l, output int w);
    w = 0;
    while (!(ctrl_tvalid && ctrl_tready) && w < 100) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, 64'(ctrl_tvalid), 64'(1));
    chk({tag, "_data"}, 64'(ctrl_tdata), 64'(d));
    chk({tag, "_user"}, 64'(ctrl_tuser), 64'(u));
    chk({tag, "_last"}, 64'(ctrl_tlast), 64'(l));
    tick();
  endtask

  task automatic setcfg(input logic ext, input int w, input int h, input int b, input int f, input int g);
    cfg_ext_mode = ext;
    cfg_width = 16'(w);
    cfg_height = 16'(h);
    cfg_bps = 4'(b);
    cfg_frames = 16'(f);
    cfg_gap = 8'(g);
  endtask

  initial begin
    int w, wsum, fd0, n, low;
    logic pend, pl;
    logic [31:0] pd;
    logic [3:0] pu;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 64'(ctrl_tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_count", 64'(frame_count), 64'(0));
    chk("rst_run_done", 64'(run_done), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    // full IIP frame, 100x100, bps 10, single frame
    setcfg(1'b0, 100, 100, 10, 1, 0);
    ctrl_tready = 1'b1;
    enable = 1'b1;
    fd0 = fd_cnt;
    tick();
    chk("lat_busy", 64'(busy), 64'(1));
    chk("lat_valid_n1", 64'(ctrl_tvalid), 64'(0));
    tick();
    chk("lat_valid_n2", 64'(ctrl_tvalid), 64'(1));
    wsum = 0;
    beat("t1_iip0", 1, 2, 0, w); wsum += w;
    beat("t1_iip1", 99, 0, 0, w); wsum += w;
    beat("t1_iip2", 99, 0, 0, w); wsum += w;
    beat("t1_iip3", 9, 0, 1, w); wsum += w;
    for (int i = 0; i < 100; i++) begin
      beat("t1_tok", 0, (i == 0) ? 1 : 0, 1, w);
      wsum += w;
    end
    beat("t1_eof0", 2, 2, 0, w); wsum += w;
    beat("t1_eof1", 0, 0, 1, w); wsum += w;
    chk("t1_bubbles", 64'(wsum), 64'(0));
    chk("t1_frame_done", 64'(frame_done), 64'(1));
    chk("t1_run_done", 64'(run_done), 64'(1));
    chk("t1_count", 64'(frame_count), 64'(1));
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_valid_after", 64'(ctrl_tvalid), 64'(0));
    tick();
    chk("t1_frame_done_pulse", 64'(frame_done), 64'(0));
    chk("t1_run_done_sticky", 64'(run_done), 64'(1));
    chk("t1_no_restart", 64'(busy), 64'(0));
    enable = 1'b0;
    tick();
    chk("t1_run_done_clear", 64'(run_done), 64'(0));
    chk("t1_fd_count", 64'(fd_cnt - fd0), 64'(1));
    // ext mode, H=3, 2 frames
    setcfg(1'b1, 4, 3, 8, 2, 0);
    fd0 = fd_cnt;
    enable = 1'b1;
    wsum = 0;
    for (int i = 0; i < 6; i++) begin
      beat("t2_tok", 0, (i % 3 == 0) ? 1 : 0, 1, w);
      if (i > 0) wsum += w;
    end
    chk("t2_bubbles", 64'(wsum), 64'(0));
    chk("t2_run_done", 64'(run_done), 64'(1));
    chk("t2_count", 64'(frame_count), 64'(2));
    tick();
    chk("t2_no_extra", 64'(ctrl_tvalid), 64'(0));
    chk("t2_fd_count", 64'(fd_cnt - fd0), 64'(2));
    enable = 1'b0;
    tick();
    // random backpressure, H=1
    setcfg(1'b0, 8, 1, 8, 1, 0);
    enable = 1'b1;
    n = 0;
    pend = 1'b0;
    pd = '0;
    pu = '0;
    pl = 1'b0;
    for (int c = 0; c < 300 && !run_done; c++) begin
      if (pend) begin
        chk("t3_hold_valid", 64'(ctrl_tvalid), 64'(1));
        chk("t3_hold_data", 64'(ctrl_tdata), 64'(pd));
        chk("t3_hold_user", 64'(ctrl_tuser), 64'(pu));
        chk("t3_hold_last", 64'(ctrl_tlast), 64'(pl));
      end
      ctrl_tready = ($urandom_range(0, 9) >= 3);
      if (ctrl_tvalid && ctrl_tready && n < 16) begin
        rd[n] = ctrl_tdata;
        ru[n] = ctrl_tuser;
        rl[n] = ctrl_tlast;
        n++;
      end
      pend = ctrl_tvalid && !ctrl_tready;
      pd = ctrl_tdata;
      pu = ctrl_tuser;
      pl = ctrl_tlast;
      tick();
    end
    chk("t3_beats", 64'(n), 64'(7));
    for (int i = 0; i < 7 && i < n; i++) begin
      chk("t3_data", 64'(rd[i]), 64'(ed[i]));
      chk("t3_user", 64'(ru[i]), 64'(eu[i]));
      chk("t3_last", 64'(rl[i]), 64'(el[i]));
    end
    ctrl_tready = 1'b1;
    enable = 1'b0;
    tick();
    // height changed mid-token-phase
    setcfg(1'b0, 4, 5, 8, 2, 0);
    enable = 1'b1;
    beat("t4_iip0", 1, 2, 0, w);
    beat("t4_iip1", 3, 0, 0, w);
    beat("t4_iip2", 4, 0, 0, w);
    beat("t4_iip3", 7, 0, 1, w);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) cfg_height = 16'd9;
      beat("t4_tok_a", 0, (i == 0) ? 1 : 0, 1, w);
    end
    beat("t4_eof0_a", 2, 2, 0, w);
    beat("t4_eof1_a", 0, 0, 1, w);
    beat("t4_iip0_b", 1, 2, 0, w);
    beat("t4_iip1_b", 3, 0, 0, w);
    beat("t4_iip2_b", 8, 0, 0, w);
    beat("t4_iip3_b", 7, 0, 1, w);
    for (int i = 0; i < 9; i++) beat("t4_tok_b", 0, (i == 0) ? 1 : 0, 1, w);
    beat("t4_eof0_b", 2, 2, 0, w);
    beat("t4_eof1_b", 0, 0, 1, w);
    chk("t4_run_done", 64'(run_done), 64'(1));
    chk("t4_count", 64'(frame_count), 64'(2));
    enable = 1'b0;
    tick();
    // reset while IIP beat2 is stalled
    setcfg(1'b0, 4, 2, 8, 1, 0);
    enable = 1'b1;
    beat("t5_iip0", 1, 2, 0, w);
    beat("t5_iip1", 3, 0, 0, w);
    ctrl_tready = 1'b0;
    chk("t5_beat2_data", 64'(ctrl_tdata), 64'(1));
    tick();
    chk("t5_beat2_held", 64'(ctrl_tvalid), 64'(1));
    rst = 1'b1;
    tick();
    chk("t5_rst_valid", 64'(ctrl_tvalid), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    ctrl_tready = 1'b1;
    beat("t5_restart_iip0", 1, 2, 0, w);
    chk("t5_restart_latency", 64'(w), 64'(2));
    beat("t5_restart_iip1", 3, 0, 0, w);
    beat("t5_restart_iip2", 1, 0, 0, w);
    beat("t5_restart_iip3", 7, 0, 1, w);
    beat("t5_tok0", 0, 1, 1, w);
    beat("t5_tok1", 0, 0, 1, w);
    beat("t5_eof0", 2, 2, 0, w);
    beat("t5_eof1", 0, 0, 1, w);
    chk("t5_run_done", 64'(run_done), 64'(1));
    enable = 1'b0;
    tick();
`ifdef VVP_ICON_SCHED_FRAME_GAP_EN
    // inter-frame gap of 4 idle cycles
    setcfg(1'b0, 4, 1, 8, 0, 4);
    enable = 1'b1;
    beat("t6_iip0", 1, 2, 0, w);
    beat("t6_iip1", 3, 0, 0, w);
    beat("t6_iip2", 0, 0, 0, w);
    beat("t6_iip3", 7, 0, 1, w);
    beat("t6_tok", 0, 1, 1, w);
    beat("t6_eof0", 2, 2, 0, w);
    beat("t6_eof1", 0, 0, 1, w);
    low = 0;
    while (!ctrl_tvalid && low < 20) begin
      chk("t6_gap_busy", 64'(busy), 64'(1));
      low++;
      tick();
    end
    chk("t6_gap_len", 64'(low), 64'(4));
    chk("t6_next_iip0_data", 64'(ctrl_tdata), 64'(1));
    chk("t6_next_iip0_user", 64'(ctrl_tuser), 64'(2));
    enable = 1'b0;
    for (int c = 0; c < 100 && busy; c++) tick();
    chk("t6_stopped", 64'(busy), 64'(0));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
